// File: rtl/dht_pkg.sv
// dht_pkg: shared states, status codes, timing constants and the
// checksum / 0.1-unit decode helpers for the DHT11/DHT22 controller.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } dht_state_t;

  typedef enum logic [1:0] {
    DHT_OK      = 2'd0,
    DHT_NORESP  = 2'd1,
    DHT_TIMEOUT = 2'd2,
    DHT_CSUM    = 2'd3
  } dht_status_t;

  localparam int unsigned START_US_DHT11 = 20000;
  localparam int unsigned START_US_DHT22 = 1100;
  localparam int unsigned FRAME_BITS     = 40;

  typedef struct packed {
    logic [15:0] hum;
    logic [15:0] temp;
  } dht_meas_t;

  function automatic logic dht_csum_ok(input logic [39:0] f);
    logic [9:0] s;
    s = {2'b00, f[39:32]} + {2'b00, f[31:24]}
      + {2'b00, f[23:16]} + {2'b00, f[15:8]};
    return s == {s[9:8], f[7:0]};
  endfunction

  // f holds b0..b3 (checksum byte stripped)
  function automatic dht_meas_t dht_decode(
    input logic        is22,
    input logic [31:0] f
  );
    dht_meas_t   m;
    logic [15:0] b0;
    logic [15:0] b2;
    logic [15:0] mag;
    logic        neg;
    b0 = {8'd0, f[31:24]};
    b2 = {8'd0, f[15:8]};
    if (is22) begin
      m.hum = f[31:16];
      mag   = {1'b0, f[14:8], f[7:0]};
      neg   = f[15];
    end else begin
      m.hum = b0 * 16'd10 + {12'd0, f[19:16]};
      mag   = b2 * 16'd10 + {12'd0, f[3:0]};
      neg   = f[7];
    end
    m.temp = neg ? (16'd0 - mag) : mag;
    return m;
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// dht_us_tick: one-cycle strobe every CLK_FREQ_HZ/1e6 clocks,
// the microsecond timebase for all phase and gap counters.
module dht_us_tick #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: single-wire DHT11/DHT22 reader with request handshake,
// auto-poll, per-phase timeouts, checksum flag and 0.1-unit decode.
module dht_sensor_ctrl
  import dht_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned MIN_GAP_MS      = 2000,
  parameter int unsigned AUTO_PERIOD_MS  = 2000,
  parameter int unsigned RESP_TIMEOUT_US = 100,
  parameter int unsigned BIT_THRESH_US   = 50
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sensor_type,
  input  logic        auto_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        rd_valid,
  output logic [1:0]  rd_status,
  output logic [39:0] raw_data,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [7:0]  err_count
);

  localparam int unsigned GAP_US = MIN_GAP_MS * 1000;
  localparam int unsigned PER_MS =
    (AUTO_PERIOD_MS > MIN_GAP_MS) ? AUTO_PERIOD_MS : MIN_GAP_MS;
  localparam int unsigned PER_US = PER_MS * 1000;

  localparam logic [15:0] TMO_LAST = 16'(RESP_TIMEOUT_US - 1);
  localparam logic [15:0] THRESH   = 16'(BIT_THRESH_US);
  localparam logic [15:0] S11_LAST = 16'(START_US_DHT11 - 1);
  localparam logic [15:0] S22_LAST = 16'(START_US_DHT22 - 1);
  localparam logic [5:0]  LAST_BIT = 6'(FRAME_BITS - 1);

  dht_state_t  r_state;
  dht_state_t  w_nxt;
  dht_status_t w_status;
  dht_meas_t   w_meas;

  logic        w_tick;
  logic        r_meta;
  logic        r_sync;
  logic        r_sync_q;
  logic        w_fall;
  logic        w_rise;
  logic [15:0] r_ph;
  logic [31:0] r_gap;
  logic        r_type;
  logic [39:0] r_shift;
  logic [5:0]  r_idx;
  logic        w_ready;
  logic        w_auto;
  logic        w_start;
  logic        w_tmo;
  logic        w_done;
  logic        w_shift;

  logic        r_oe;
  logic        r_rd_valid;
  logic [1:0]  r_status;
  logic [39:0] r_raw;
  logic [15:0] r_hum;
  logic [15:0] r_temp;
  logic [7:0]  r_err;

  dht_us_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .o_tick(w_tick)
  );

  // Idle-high line: reset the chain to 1 so no edge appears at startup
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_q <= 1'b1;
    end else begin
      r_meta   <= dht_in;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
    end
  end

  assign w_fall  = r_sync_q & ~r_sync;
  assign w_rise  = ~r_sync_q & r_sync;
  assign w_ready = (r_state == S_IDLE) && (r_gap >= GAP_US);
  assign w_auto  = auto_en && (r_state == S_IDLE) && (r_gap >= PER_US);
  assign w_start = (req_valid && w_ready) || w_auto;
  assign w_tmo   = w_tick && (r_ph >= TMO_LAST);
  assign w_meas  = dht_decode(r_type, r_shift[39:8]);

  always_comb begin
    w_nxt    = r_state;
    w_done   = 1'b0;
    w_status = DHT_OK;
    w_shift  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_nxt = S_START_LOW;
      end
      S_START_LOW: begin
        if (w_tick && r_ph >= (r_type ? S22_LAST : S11_LAST))
          w_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_fall) begin
          w_nxt = S_RESP_LOW;
        end else if (w_tmo) begin
          w_nxt    = S_IDLE;
          w_done   = 1'b1;
          w_status = DHT_NORESP;
        end
      end
      S_RESP_LOW: begin
        if (w_rise) begin
          w_nxt = S_RESP_HIGH;
        end else if (w_tmo) begin
          w_nxt    = S_IDLE;
          w_done   = 1'b1;
          w_status = DHT_TIMEOUT;
        end
      end
      S_RESP_HIGH: begin
        if (w_fall) begin
          w_nxt = S_BIT_LOW;
        end else if (w_tmo) begin
          w_nxt    = S_IDLE;
          w_done   = 1'b1;
          w_status = DHT_TIMEOUT;
        end
      end
      S_BIT_LOW: begin
        if (w_rise) begin
          w_nxt = S_BIT_HIGH;
        end else if (w_tmo) begin
          w_nxt    = S_IDLE;
          w_done   = 1'b1;
          w_status = DHT_TIMEOUT;
        end
      end
      S_BIT_HIGH: begin
        if (w_fall) begin
          w_shift = 1'b1;
          w_nxt   = (r_idx == LAST_BIT) ? S_CHECK : S_BIT_LOW;
        end else if (w_tmo) begin
          w_nxt    = S_IDLE;
          w_done   = 1'b1;
          w_status = DHT_TIMEOUT;
        end
      end
      S_CHECK: begin
        w_nxt    = S_IDLE;
        w_done   = 1'b1;
        w_status = dht_csum_ok(r_shift) ? DHT_OK : DHT_CSUM;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_oe    <= 1'b0;
      r_ph    <= '0;
      r_gap   <= '0;
      r_type  <= 1'b0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_oe    <= (w_nxt == S_START_LOW);
      if (w_nxt != r_state) begin
        r_ph <= '0;
      end else if (w_tick && r_ph != '1) begin
        r_ph <= r_ph + 1'b1;
      end
      if (w_start) begin
        r_gap  <= '0;
        r_type <= sensor_type;
      end else if (w_tick && r_gap != '1) begin
        r_gap <= r_gap + 1'b1;
      end
      if (r_state == S_RESP_HIGH) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_idx   <= r_idx + 1'b1;
        r_shift <= {r_shift[38:0], r_ph > THRESH};
      end
    end
  end

  // Result strobe lands one cycle after the terminating event
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_valid <= 1'b0;
      r_status   <= 2'd0;
      r_raw      <= '0;
      r_hum      <= '0;
      r_temp     <= '0;
      r_err      <= '0;
    end else begin
      r_rd_valid <= w_done;
      if (w_done) r_status <= w_status;
      if (r_state == S_CHECK) r_raw <= r_shift;
      if (w_done && w_status == DHT_OK) begin
        r_hum  <= w_meas.hum;
        r_temp <= w_meas.temp;
      end
      if (w_done && w_status != DHT_OK && r_err != 8'hFF)
        r_err <= r_err + 1'b1;
    end
  end

  assign req_ready   = w_ready;
  assign dht_oe      = r_oe;
  assign rd_valid    = r_rd_valid;
  assign rd_status   = r_status;
  assign raw_data    = r_raw;
  assign humidity    = r_hum;
  assign temperature = r_temp;
  assign err_count   = r_err;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: directed frames via a wired-AND sensor model;
// expected results queued by stimulus, checked on each rd_valid.
`timescale 1ns/1ps
module tb_dht_sensor_ctrl;

  typedef struct {
    logic [1:0]  st;
    logic [39:0] raw;
    logic [15:0] hum;
    logic [15:0] temp;
    logic [7:0]  err;
    longint      cyc;
  } exp_t;

  logic        sys_clk     = 1'b0;
  logic        sys_rst     = 1'b1;
  logic        sensor_type = 1'b0;
  logic        auto_en     = 1'b0;
  logic        req_valid   = 1'b0;
  logic        sens_low    = 1'b0;
  logic        dht_in;
  logic        req_ready;
  logic        dht_oe;
  logic        rd_valid;
  logic [1:0]  rd_status;
  logic [39:0] raw_data;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic [7:0]  err_count;

  exp_t   q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  longint cyc    = 0;
  longint acc_cyc;
  longint prev_acc;
  int     len;

  assign dht_in = ~(dht_oe | sens_low);

  always #500 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  dht_sensor_ctrl #(
    .CLK_FREQ_HZ    (1_000_000),
    .MIN_GAP_MS     (1),
    .AUTO_PERIOD_MS (1),
    .RESP_TIMEOUT_US(100),
    .BIT_THRESH_US  (50)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .sensor_type(sensor_type),
    .auto_en    (auto_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .rd_valid   (rd_valid),
    .rd_status  (rd_status),
    .raw_data   (raw_data),
    .humidity   (humidity),
    .temperature(temperature),
    .err_count  (err_count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [1:0] st, input logic [39:0] raw,
                      input logic [15:0] hum, input logic [15:0] temp,
                      input logic [7:0] err, input longint c);
    exp_t e;
    e.st = st; e.raw = raw; e.hum = hum;
    e.temp = temp; e.err = err; e.cyc = c;
    q.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst && rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected rd_valid", rd_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("rd_status", rd_status, e.st);
        chk("raw_data", raw_data, e.raw);
        chk("humidity", humidity, e.hum);
        chk("temperature", temperature, e.temp);
        chk("err_count", err_count, e.err);
        chk("dht_oe at result", dht_oe, 1'b0);
        if (e.cyc >= 0) chk("rd_valid timing", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic lo, input int n);
    sens_low = lo;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic sensor_send(input logic [39:0] f, input int nbits);
    drive(1'b0, 20);
    drive(1'b1, 80);
    drive(1'b0, 80);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, 50);
      drive(1'b0, f[39-i] ? 70 : 26);
    end
    drive(1'b1, 50);
    sens_low = 1'b0;
  endtask

  task automatic issue_req(input logic typ);
    int i;
    i = 0;
    sensor_type = typ;
    req_valid   = 1'b1;
    while (req_ready !== 1'b1 && i < 5000) begin
      @(negedge sys_clk); i++;
    end
    chk("req_ready rises", req_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge sys_clk);
    req_valid = 1'b0;
    chk("req_ready while busy", req_ready, 1'b0);
  endtask

  task automatic measure_start(output int n);
    n = 0;
    while (dht_oe === 1'b1 && n < 30000) begin
      @(negedge sys_clk); n++;
    end
  endtask

  task automatic wait_q(input string nm);
    int i;
    i = 0;
    while (q.size() != 0 && i < 2000) begin
      @(negedge sys_clk); i++;
    end
    chk(nm, q.size(), 0);
  endtask

  task automatic reset_check(input string tag);
    int n;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk({tag, " dht_oe"}, dht_oe, 1'b0);
    chk({tag, " rd_valid"}, rd_valid, 1'b0);
    chk({tag, " rd_status"}, rd_status, 2'd0);
    chk({tag, " raw_data"}, raw_data, 40'd0);
    chk({tag, " humidity"}, humidity, 16'd0);
    chk({tag, " temperature"}, temperature, 16'd0);
    chk({tag, " err_count"}, err_count, 8'd0);
    chk({tag, " req_ready"}, req_ready, 1'b0);
    sys_rst = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 5000) begin
      @(negedge sys_clk); n++;
    end
    chk({tag, " ready after gap"}, n, 1000);
  endtask

  initial begin
    #150_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_check("por");

    issue_req(1'b0);
    measure_start(len);
    chk("dht11 start_low us", len, 20000);
    push(2'd0, 40'h37_00_19_05_55, 16'd550, 16'd255, 8'd0, -1);
    sensor_send(40'h37_00_19_05_55, 40);
    wait_q("dht11 ok result");

    issue_req(1'b1);
    measure_start(len);
    chk("dht22 start_low us", len, 1100);
    push(2'd0, 40'h02_8C_80_65_73, 16'd652, 16'hFF9B, 8'd0, -1);
    sensor_send(40'h02_8C_80_65_73, 40);
    wait_q("dht22 ok result");

    issue_req(1'b1);
    measure_start(len);
    push(2'd1, 40'h02_8C_80_65_73, 16'd652, 16'hFF9B, 8'd1, cyc + 100);
    wait_q("noresp result");

    issue_req(1'b1);
    measure_start(len);
    push(2'd3, 40'h37_00_19_05_56, 16'd652, 16'hFF9B, 8'd2, -1);
    sensor_send(40'h37_00_19_05_56, 40);
    wait_q("csum result");

    issue_req(1'b1);
    prev_acc = acc_cyc;
    measure_start(len);
    push(2'd2, 40'h37_00_19_05_56, 16'd652, 16'hFF9B, 8'd3, -1);
    sensor_send(40'h02_8C_80_65_73, 12);
    wait_q("frame timeout result");

    issue_req(1'b1);
    chk("start-to-start gap", (acc_cyc - prev_acc) >= 1000, 1'b1);
    measure_start(len);
    sensor_send(40'h02_8C_80_65_73, 6);
    repeat (10) @(negedge sys_clk);
    reset_check("mid-txn");

    sensor_type = 1'b1;
    auto_en     = 1'b1;
    len = 0;
    while (dht_oe !== 1'b1 && len < 100) begin
      @(negedge sys_clk); len++;
    end
    chk("auto trigger start", dht_oe, 1'b1);
    auto_en = 1'b0;
    measure_start(len);
    chk("auto start_low us", len, 1100);
    push(2'd0, 40'h01_F4_00_FA_EF, 16'd500, 16'd250, 8'd0, -1);
    sensor_send(40'h01_F4_00_FA_EF, 40);
    wait_q("auto ok result");

    repeat (50) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dht_sensor_ctrl.md
Name: dht_sensor_ctrl

Overview:
- Parametrised single-wire controller for DHT11/DHT22 temperature/humidity sensors; successor to the fixed-timing DHT11 controller.
- Adds a request/ready handshake and an optional auto-poll mode.
- Adds per-phase timeouts with status codes, a checksum flag and a minimum inter-read gap.
- Decodes results to 0.1-unit values; sits between the sensor pad and the host register/UART layer.

Parameters:
- CLK_FREQ_HZ, 50_000_000, sys_clk frequency; must be a multiple of 1 MHz.
- MIN_GAP_MS, 2000, minimum time between transaction starts; also the hold-off after reset.
- AUTO_PERIOD_MS, 2000, auto-poll period when auto_en=1; effective period is max(AUTO_PERIOD_MS, MIN_GAP_MS).
- RESP_TIMEOUT_US, 100, maximum duration of any sensor-driven phase.
- BIT_THRESH_US, 50, a high pulse longer than this decodes as 1.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- sensor_type  in  1  0=DHT11, 1=DHT22; sampled when a transaction starts
- auto_en  in  1  enables periodic self-triggered reads
- req_valid  in  1  host read request
- req_ready  out  1  high when IDLE and the gap has elapsed
- dht_in  in  1  raw pad input (asynchronous)
- dht_oe  out  1  1 = drive the line low; 0 = release (external pull-up)
- rd_valid  out  1  one-cycle result strobe
- rd_status  out  2  0 OK, 1 no response, 2 frame timeout, 3 checksum error
- raw_data  out  40  last fully received frame, MSB first
- humidity  out  16  unsigned, 0.1 %RH
- temperature  out  16  signed two's complement, 0.1 °C
- err_count  out  8  saturating count of non-OK results

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - State goes to IDLE; dht_oe=0; rd_valid=0; rd_status=0.
  - raw_data, humidity, temperature and err_count are cleared to 0.
  - The gap counter restarts from 0, so req_ready stays low for MIN_GAP_MS after reset.
  - Reset mid-transaction behaves the same: the line is released on the next cycle.
- Input path: dht_in passes through a 2-flop synchroniser; edges are detected on the synchronised value (2-3 cycle latency).
- Timebase: 1 µs tick. All phase counters count ticks, saturate at their maximum, and clear on state entry.
- Start of a transaction:
  - req_valid && req_ready starts one transaction (accepted in that cycle).
  - An auto trigger starts one when auto_en=1, the period has elapsed and the block is IDLE.
  - A host request and an auto trigger in the same cycle produce a single transaction.
  - Requests while busy are not accepted (req_ready=0).
- States:
  - IDLE: dht_oe=0. Leave on a start event; the gap and period counters restart at the start.
  - START_LOW: dht_oe=1 for 20000 µs (DHT11) or 1100 µs (DHT22), then go to RELEASE.
  - RELEASE: dht_oe=0 from here on. A falling edge goes to RESP_LOW. No falling edge within RESP_TIMEOUT_US ends with status 1.
  - RESP_LOW: a rising edge goes to RESP_HIGH.
  - RESP_HIGH: a falling edge goes to BIT_LOW with bit_idx=0.
  - BIT_LOW: a rising edge goes to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in (width_us > BIT_THRESH_US) and increment bit_idx. bit_idx reaching 40 goes to CHECK, otherwise back to BIT_LOW.
  - Any of RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH exceeding RESP_TIMEOUT_US ends with status 2. raw_data is not updated.
  - CHECK (1 cycle):
    - raw_data is loaded with the frame.
    - The checksum passes when (b0+b1+b2+b3) mod 256 == b4, where b0 = raw[39:32]. Pass gives status 0; fail gives status 3.
    - Then IDLE.
- Result: rd_valid pulses for one cycle, in the cycle after the terminating event, together with rd_status.
  - humidity/temperature update only on status 0, in the same cycle as rd_valid.
  - err_count increments on any non-zero status and saturates at 255.
- Decode, DHT11:
  - humidity = b0*10 + b1[3:0].
  - temperature = ±(b2*10 + b3[3:0]); negative if b3[7]=1.
- Decode, DHT22:
  - humidity = {b0,b1}.
  - temperature = ±{b2[6:0],b3}; negative if b2[7]=1.
  - A negative magnitude of 0 yields 0.
- Arithmetic: all decode arithmetic is 16-bit; the checksum is computed at 10 bits and compared on the low 8 bits.

Decomposition:
- Package dht_pkg holds:
  - state enum;
  - status codes (DHT_OK, DHT_NORESP, DHT_TIMEOUT, DHT_CSUM);
  - start-low constants 20000 and 1100;
  - FRAME_BITS=40.
- Sub-module dht_us_tick: parameter CLK_FREQ_HZ; emits a 1-cycle tick every CLK_FREQ_HZ/1e6 cycles; synchronous reset.

Test Plan:
- Bench setup: CLK_FREQ_HZ=1_000_000, MIN_GAP_MS=1; sensor model with 80/80 µs response and 50 µs low + 26 µs (0) or 70 µs (1) high per bit.
- DHT11 frame 0x37_00_19_05_55 -> status 0, humidity=550, temperature=255, raw_data=0x3700190555.
- DHT22 frame 0x02_8C_80_65_73 -> status 0, humidity=652, temperature=-101 (0xFF9B); START_LOW measured at 1100 µs.
- Silent sensor -> rd_valid with status 1 exactly 100 µs after release; err_count=1; dht_oe=0.
- Frame 0x37_00_19_05_56 -> status 3; raw_data updated; humidity/temperature unchanged.
- Line stuck high after bit 12 -> status 2 after 100 µs. Second req_valid issued immediately -> req_ready=0 until 1 ms after the previous start.
- sys_rst asserted during BIT_HIGH -> next cycle dht_oe=0, state IDLE, outputs 0, no rd_valid; req_ready returns only after MIN_GAP_MS.
